pcpi_dispatch: RTL

Front-end between the PicoRV32 PCPI port and the coprocessors behind it: riscv_m_unit (RV32M) and the custom-instruction unit.
- Decodes each offered instruction and registers the instruction and operands.
- Issues the instruction to exactly one unit and holds the core with pcpi_wait.
- Registers the unit's result and returns it to the core as a one-cycle pcpi_ready pulse.
- Guards against a hung unit with a cycle timeout.

---
 rtl/pcpi_dispatch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pcpi_dispatch.sv
// Purpose: decodes PCPI instructions and dispatches each one to riscv_m_unit (RV32M) or the custom unit.
// Latency: pcpi_wait one cycle after the valid sample, pcpi_ready one cycle after the unit's ready (or the timeout).
// Backpressure: the core is stalled with pcpi_wait for the whole issue; a new offer is taken only in IDLE.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2             instruction offered by the core
//   pcpi_wr/rd/wait/ready               response and stall back to the core
//   m_* / cx_*                          issue valid and result handshake of the two units
//   instruction/rs1/rs2                 registered instruction and operands shared by both units
//   timeout_err                         sticky flag, set when a unit fails to answer in time
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        m_wr,
    input  logic [31:0] m_rd,
    input  logic        m_busy,
    output logic        cx_valid,
    input  logic        cx_ready,
    input  logic        cx_wr,
    input  logic [31:0] cx_rd,
    input  logic        cx_busy,
    output logic [31:0] instruction,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, RUN, RESP, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel_cx;
    logic             issue_m;
    logic             issue_cx;

    logic        is_m;
    logic        is_cx;
    logic        sel_ready;
    logic        sel_wr;
    logic [31:0] sel_rd;

    // Busy lines are observation-only; they never steer the FSM.
    logic unused_busy;
    assign unused_busy = m_busy ^ cx_busy;

    assign is_m  = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign is_cx = (pcpi_insn[6:0] == 7'b0001011);

    // Only the selected unit's handshake is ever looked at.
    assign sel_ready = sel_cx ? cx_ready : m_ready;
    assign sel_wr    = sel_cx ? cx_wr    : m_wr;
    assign sel_rd    = sel_cx ? cx_rd    : m_rd;

    // Gating with pcpi_valid lets an abort drop the issue in the same cycle
    // the core withdraws, rather than one cycle later.
    assign m_valid  = issue_m  & pcpi_valid;
    assign cx_valid = issue_cx & pcpi_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_cx      <= 1'b0;
            issue_m     <= 1'b0;
            issue_cx    <= 1'b0;
            pcpi_wait   <= 1'b0;
            pcpi_ready  <= 1'b0;
            pcpi_wr     <= 1'b0;
            pcpi_rd     <= '0;
            instruction <= '0;
            rs1         <= '0;
            rs2         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A miss is left unclaimed so the core's own illegal-instruction trap fires.
                    if (pcpi_valid && (is_m || is_cx)) begin
                        instruction <= pcpi_insn;
                        rs1         <= pcpi_rs1;
                        rs2         <= pcpi_rs2;
                        sel_cx      <= is_cx;
                        issue_m     <= is_m && !is_cx;
                        issue_cx    <= is_cx;
                        cnt         <= '0;
                        pcpi_wait   <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!pcpi_valid) begin
                        issue_m   <= 1'b0;
                        issue_cx  <= 1'b0;
                        pcpi_wait <= 1'b0;
                        state     <= IDLE;
                    end else if (sel_ready || (cnt == CNT_LAST)) begin
                        // Ready wins over a timeout landing in the same cycle.
                        if (sel_ready) begin
                            pcpi_rd <= sel_rd;
                            pcpi_wr <= sel_wr;
                        end else begin
                            pcpi_rd     <= '0;
                            pcpi_wr     <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                        issue_m    <= 1'b0;
                        issue_cx   <= 1'b0;
                        pcpi_wait  <= 1'b0;
                        pcpi_ready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    pcpi_ready <= 1'b0;
                    pcpi_wr    <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: begin
                    // The core still shows the old valid here; skip it.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
